// File: rtl/pattern_pulse_generator.sv
// Serial pattern pulse generator: plays a WIDTH-bit shadow pattern one bit per clock.
// Optional PULSE_POLARITY_EN adds an invert input controlling output polarity.
`timescale 1ns/1ps
module pattern_pulse_generator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] Q_in,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             dir,
  input  logic [CNT_W-1:0] repeat_cnt,
`ifdef PULSE_POLARITY_EN
  input  logic             invert,
`endif
  output logic             Q_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BitW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             sel_bit;
`ifdef PULSE_POLARITY_EN
  logic             inv_q, inv_d;
`endif

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    work_d    = work_q;
    bit_cnt_d = bit_cnt_q;
    per_cnt_d = per_cnt_q;
    rep_d     = rep_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
`ifdef PULSE_POLARITY_EN
    inv_d     = inv_q;
`endif
    if (load) begin
      shadow_d = Q_in;
      work_d   = Q_in;
      state_d  = StIdle;
    end else if (stop) begin
      state_d = StIdle;
    end else if (start && (state_q == StIdle)) begin
      work_d    = shadow_q;
      bit_cnt_d = '0;
      per_cnt_d = '0;
      mode_d    = mode;
      dir_d     = dir;
      // A zero repeat count behaves as a single period.
      rep_d     = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
`ifdef PULSE_POLARITY_EN
      inv_d     = invert;
`endif
      state_d   = StRun;
    end else if (state_q == StRun) begin
      if (dir_q) begin
        work_d = {work_q[0], work_q[WIDTH-1:1]};
      end else begin
        work_d = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      end
      bit_cnt_d = bit_cnt_q + BitW'(1);
      if (bit_cnt_q == LastBit) begin
        bit_cnt_d = '0;
        per_cnt_d = per_cnt_q + CNT_W'(1);
        if (mode_q && (per_cnt_d == rep_q)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      shadow_q  <= '0;
      work_q    <= '0;
      bit_cnt_q <= '0;
      per_cnt_q <= '0;
      rep_q     <= '0;
      mode_q    <= 1'b0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef PULSE_POLARITY_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      work_q    <= work_d;
      bit_cnt_q <= bit_cnt_d;
      per_cnt_q <= per_cnt_d;
      rep_q     <= rep_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
`ifdef PULSE_POLARITY_EN
      inv_q     <= inv_d;
`endif
    end
  end

  always_comb begin
    sel_bit = dir_q ? work_q[0] : work_q[WIDTH-1];
`ifdef PULSE_POLARITY_EN
    Q_out = (state_q == StRun) ? (sel_bit ^ inv_q) : invert;
`else
    Q_out = (state_q == StRun) ? sel_bit : 1'b0;
`endif
    busy = (state_q == StRun);
    done = done_q;
  end

endmodule

// File: tb/tb_pattern_pulse_generator.sv
// Directed bench for pattern_pulse_generator (WIDTH=16, CNT_W=8).
`timescale 1ns/1ps
module tb_pattern_pulse_generator;

  logic        CLK;
  logic        RST;
  logic [15:0] Q_in;
  logic        load;
  logic        start;
  logic        stop;
  logic        mode;
  logic        dir;
  logic [7:0]  repeat_cnt;
  logic        invert;
  logic        Q_out;
  logic        busy;
  logic        done;

  int          n_vec;
  int          n_bad;
  logic        inv_exp;
  logic [15:0] cap;

  pattern_pulse_generator #(
    .WIDTH(16),
    .CNT_W(8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Q_in      (Q_in),
    .load      (load),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .dir       (dir),
    .repeat_cnt(repeat_cnt),
`ifdef PULSE_POLARITY_EN
    .invert    (invert),
`endif
    .Q_out     (Q_out),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic go(input logic m, input logic d, input logic [7:0] rep);
    mode       = m;
    dir        = d;
    repeat_cnt = rep;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Checks n periods of playback starting from the first RUN cycle, then the done pulse.
  // seq returns the first 16 output bits, first-out bit in the MSB.
  task automatic play(input logic [15:0] pat, input logic d, input int n,
                      output logic [15:0] seq);
    int idx;
    seq = '0;
    for (int c = 0; c < n * 16; c++) begin
      idx = d ? (c % 16) : (15 - (c % 16));
      if (c < 16) seq = {seq[14:0], Q_out};
      chk("q_run", Q_out, pat[idx] ^ inv_exp);
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      tick();
    end
    chk("busy_end", busy, 0);
    chk("done_pulse", done, 1);
    chk("q_idle", Q_out, inv_exp);
    tick();
    chk("done_clear", done, 0);
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    inv_exp = 1'b0;
    invert  = 1'b0;
    RST     = 1'b1;
    Q_in    = 16'($urandom);
    load    = 1'($urandom);
    start   = 1'($urandom);
    stop    = 1'($urandom);
    mode    = 1'($urandom);
    dir     = 1'($urandom);
    repeat_cnt = 8'($urandom);
    tick();
    chk("rst_q", Q_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    Q_in  = 16'($urandom);
    start = 1'b1;
    tick();
    chk("rst2_busy", busy, 0);
    RST   = 1'b0;
    Q_in  = '0;
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_q", Q_out, 0);

    // Shadow cleared by reset: plays zeros
    go(1'b1, 1'b0, 8'd1);
    play(16'h0000, 1'b0, 1, cap);
    chk("seq_zero", cap, 16'h0000);

    Q_in = 16'hA5F0;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("load_idle", busy, 0);

    go(1'b1, 1'b0, 8'd1);
    play(16'hA5F0, 1'b0, 1, cap);
    chk("seq_msb", cap, 16'hA5F0);

    go(1'b1, 1'b1, 8'd1);
    play(16'hA5F0, 1'b1, 1, cap);
    chk("seq_lsb", cap, 16'h0FA5);

    go(1'b1, 1'b0, 8'd1);
    play(16'hA5F0, 1'b0, 1, cap);
    chk("seq_restore", cap, 16'hA5F0);

    go(1'b1, 1'b0, 8'd3);
    play(16'hA5F0, 1'b0, 3, cap);
    go(1'b1, 1'b0, 8'd0);
    play(16'hA5F0, 1'b0, 1, cap);
    chk("seq_rep0", cap, 16'hA5F0);

    // Continuous run, stop on the 20th RUN cycle
    go(1'b0, 1'b0, 8'd1);
    for (int c = 0; c < 19; c++) begin
      chk("cont_q", Q_out, 16'hA5F0 >> (15 - (c % 16)) & 16'h1);
      chk("cont_busy", busy, 1);
      tick();
    end
    chk("cont_q20", Q_out, 0);
    chk("cont_busy20", busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_q", Q_out, 0);
    chk("stop_done", done, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stop_nodone", done, 0);
    end
    go(1'b1, 1'b0, 8'd1);
    play(16'hA5F0, 1'b0, 1, cap);
    chk("seq_restart", cap, 16'hA5F0);

    // load wins over start on the same edge
    Q_in  = 16'h1234;
    load  = 1'b1;
    start = 1'b1;
    tick();
    load  = 1'b0;
    start = 1'b0;
    chk("ldst_busy", busy, 0);
    tick();
    chk("ldst_busy2", busy, 0);
    go(1'b1, 1'b0, 8'd1);
    play(16'h1234, 1'b0, 1, cap);
    chk("seq_1234", cap, 16'h1234);

    go(1'b1, 1'b0, 8'd3);
    repeat (4) tick();
    chk("mid_busy", busy, 1);
    Q_in = 16'hFFFF;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("ldrun_busy", busy, 0);
    chk("ldrun_q", Q_out, 0);
    chk("ldrun_done", done, 0);
    tick();
    chk("ldrun_nodone", done, 0);
    go(1'b1, 1'b1, 8'd1);
    play(16'hFFFF, 1'b1, 1, cap);
    chk("seq_ffff", cap, 16'hFFFF);

`ifdef PULSE_POLARITY_EN
    invert  = 1'b1;
    inv_exp = 1'b1;
    Q_in    = 16'hA5F0;
    load    = 1'b1;
    tick();
    load    = 1'b0;
    chk("inv_idle", Q_out, 1);
    go(1'b1, 1'b0, 8'd1);
    play(16'hA5F0, 1'b0, 1, cap);
    chk("seq_inv", cap, 16'h5A0F);
    invert  = 1'b0;
    inv_exp = 1'b0;
    #1;
    chk("inv_off_idle", Q_out, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
